// File: rtl/systolic_pkg.sv
// Shared constants, element/accumulator types and a packed-element
// selector for the 3x3 systolic matrix multiplier.
package systolic_pkg;

    localparam int ELEM_W    = 4;
    localparam int N         = 3;
    localparam int WIDTH     = N * ELEM_W;
    localparam int WIDTH_SUM = 8;
    localparam int LAST_STEP = 7;

    // Step counter value at which the run is complete.
    localparam logic [2:0] LAST_CNT = 3'(LAST_STEP);

    typedef logic [ELEM_W-1:0]    elem_t;
    typedef logic [WIDTH_SUM-1:0] acc_t;

    // Element k (0-based) of a packed row/column; element 0 sits in
    // the most significant nibble.
    function automatic elem_t elem_at(
        input logic [WIDTH-1:0] vec,
        input logic [1:0]       k
    );
        elem_t e;
        case (k)
            2'd0:    e = vec[11:8];
            2'd1:    e = vec[7:4];
            default: e = vec[3:0];
        endcase
        return e;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the systolic grid.
// Ports:
//   CLK, RST      clock and asynchronous active-high reset
//   enable        advance one step on this edge
//   hold          run finished; freeze regardless of enable
//   a_in, b_in    operands from the left / top neighbour (or feeder)
//   a_out, b_out  registered operands to the right / bottom neighbour
//   acc           running sum of a_in*b_in, modulo 2^WIDTH_SUM
module systolic_pe
    import systolic_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  enable,
    input  logic  hold,
    input  elem_t a_in,
    input  elem_t b_in,
    output elem_t a_out,
    output elem_t b_out,
    output acc_t  acc
);

    acc_t prod;

    // 4x4 unsigned product fits the accumulator width exactly.
    assign prod = acc_t'(a_in) * acc_t'(b_in);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (enable && !hold) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod;
        end
    end

endmodule

// File: rtl/systolic_array_3x3.sv
// 3x3 output-stationary systolic multiplier: C = A x B, 4-bit elements.
// Ports:
//   CLK, RST, ENABLE        clock, async active-high reset, step enable
//   A_ROW1..3               rows of A, element 1 in bits [11:8]
//   B_COLOUM1..3            columns of B, element 1 in bits [11:8]
//   C_OUT_1x1..C_OUT_3x3    per-PE accumulators (row-major names)
//   MULTI_OVER              high once all nine results are final
module systolic_array_3x3
    import systolic_pkg::*;
#(
    parameter int WIDTH     = systolic_pkg::WIDTH,
    parameter int WIDTH_SUM = systolic_pkg::WIDTH_SUM
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic [WIDTH-1:0]     A_ROW1,
    input  logic [WIDTH-1:0]     A_ROW2,
    input  logic [WIDTH-1:0]     A_ROW3,
    input  logic [WIDTH-1:0]     B_COLOUM1,
    input  logic [WIDTH-1:0]     B_COLOUM2,
    input  logic [WIDTH-1:0]     B_COLOUM3,
    output logic [WIDTH_SUM-1:0] C_OUT_1x1,
    output logic [WIDTH_SUM-1:0] C_OUT_1x2,
    output logic [WIDTH_SUM-1:0] C_OUT_1x3,
    output logic [WIDTH_SUM-1:0] C_OUT_2x1,
    output logic [WIDTH_SUM-1:0] C_OUT_2x2,
    output logic [WIDTH_SUM-1:0] C_OUT_2x3,
    output logic [WIDTH_SUM-1:0] C_OUT_3x1,
    output logic [WIDTH_SUM-1:0] C_OUT_3x2,
    output logic [WIDTH_SUM-1:0] C_OUT_3x3,
    output logic                 MULTI_OVER
);

    logic [2:0] cnt;
    logic       hold;
    logic       step;
    logic       done;

    logic [WIDTH-1:0] a_rows [N];
    logic [WIDTH-1:0] b_cols [N];

    elem_t feed_a [N];
    elem_t feed_b [N];

    // Inter-PE links; last column/row outputs leave the grid unused.
    elem_t a_pipe [N][N-1];
    elem_t b_pipe [N-1][N];
    elem_t unused_a [N];
    elem_t unused_b [N];

    acc_t acc [N][N];

    assign a_rows[0] = A_ROW1;
    assign a_rows[1] = A_ROW2;
    assign a_rows[2] = A_ROW3;
    assign b_cols[0] = B_COLOUM1;
    assign b_cols[1] = B_COLOUM2;
    assign b_cols[2] = B_COLOUM3;

    assign hold = (cnt == LAST_CNT);
    assign step = ENABLE && !hold;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (step) begin
            cnt <= cnt + 3'd1;
            // Flag rises on the same edge that moves cnt to its last value.
            if (cnt == LAST_CNT - 3'd1) begin
                done <= 1'b1;
            end
        end
    end

    assign MULTI_OVER = done;

    // Diagonal skew: row i / column j starts i / j steps late, so
    // PE(i,j) sees A[i][k] and B[k][j] together at cnt = k+i+j.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            feed_a[i] = '0;
            feed_b[i] = '0;
            if (cnt >= 3'(i) && (cnt - 3'(i)) <= 3'd2) begin
                feed_a[i] = elem_at(a_rows[i], 2'(cnt - 3'(i)));
                feed_b[i] = elem_at(b_cols[i], 2'(cnt - 3'(i)));
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            elem_t a_in;
            elem_t b_in;
            elem_t a_out;
            elem_t b_out;

            if (j == 0) begin : g_a_edge
                assign a_in = feed_a[i];
            end else begin : g_a_link
                assign a_in = a_pipe[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in = feed_b[j];
            end else begin : g_b_link
                assign b_in = b_pipe[i-1][j];
            end

            if (j < N - 1) begin : g_a_fwd
                assign a_pipe[i][j] = a_out;
            end else begin : g_a_end
                assign unused_a[i] = a_out;
            end

            if (i < N - 1) begin : g_b_fwd
                assign b_pipe[i][j] = b_out;
            end else begin : g_b_end
                assign unused_b[j] = b_out;
            end

            systolic_pe u_pe (
                .CLK    (CLK),
                .RST    (RST),
                .enable (ENABLE),
                .hold   (hold),
                .a_in   (a_in),
                .b_in   (b_in),
                .a_out  (a_out),
                .b_out  (b_out),
                .acc    (acc[i][j])
            );
        end
    end

    assign C_OUT_1x1 = acc[0][0];
    assign C_OUT_1x2 = acc[0][1];
    assign C_OUT_1x3 = acc[0][2];
    assign C_OUT_2x1 = acc[1][0];
    assign C_OUT_2x2 = acc[1][1];
    assign C_OUT_2x3 = acc[1][2];
    assign C_OUT_3x1 = acc[2][0];
    assign C_OUT_3x2 = acc[2][1];
    assign C_OUT_3x3 = acc[2][2];

endmodule

// File: tb/tb_systolic_array_3x3.sv
// Self-checking bench for systolic_array_3x3 against a matrix-level
// model of partial sums after n enabled steps.
module tb_systolic_array_3x3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] a_row [3];
    logic [11:0] b_col [3];
    logic [7:0]  c_out [3][3];
    logic        multi_over;

    int ma [3][3];
    int mb [3][3];
    int steps = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_array_3x3 dut (
        .CLK        (clk),
        .RST        (rst),
        .ENABLE     (enable),
        .A_ROW1     (a_row[0]),
        .A_ROW2     (a_row[1]),
        .A_ROW3     (a_row[2]),
        .B_COLOUM1  (b_col[0]),
        .B_COLOUM2  (b_col[1]),
        .B_COLOUM3  (b_col[2]),
        .C_OUT_1x1  (c_out[0][0]),
        .C_OUT_1x2  (c_out[0][1]),
        .C_OUT_1x3  (c_out[0][2]),
        .C_OUT_2x1  (c_out[1][0]),
        .C_OUT_2x2  (c_out[1][1]),
        .C_OUT_2x3  (c_out[1][2]),
        .C_OUT_3x1  (c_out[2][0]),
        .C_OUT_3x2  (c_out[2][1]),
        .C_OUT_3x3  (c_out[2][2]),
        .MULTI_OVER (multi_over)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Sum of A[i][k]*B[k][j] over products already consumed after n
    // enabled steps (product k reaches PE(i,j) at step k+i+j).
    function automatic int model_c(int n, int i, int j);
        int s = 0;
        for (int k = 0; k < 3; k++) begin
            if (k + i + j < n) s += ma[i][k] * mb[k][j];
        end
        return s % 256;
    endfunction

    task automatic check_grid(input string tag, input int n);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                check($sformatf("%s c%0d%0d", tag, i + 1, j + 1),
                      int'(c_out[i][j]), model_c(n, i, j));
            end
        end
        check({tag, " done"}, int'(multi_over), int'(n >= 7));
    endtask

    task automatic load();
        for (int i = 0; i < 3; i++) begin
            a_row[i] = {4'(ma[i][0]), 4'(ma[i][1]), 4'(ma[i][2])};
            b_col[i] = {4'(mb[0][i]), 4'(mb[1][i]), 4'(mb[2][i])};
        end
    endtask

    task automatic set_hex(input logic [11:0] r0, r1, r2, c0, c1, c2);
        logic [11:0] r [3];
        logic [11:0] c [3];
        r[0] = r0; r[1] = r1; r[2] = r2;
        c[0] = c0; c[1] = c1; c[2] = c2;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                ma[i][k] = int'(r[i][11 - 4 * k -: 4]);
                mb[k][i] = int'(c[i][11 - 4 * k -: 4]);
            end
        end
        load();
    endtask

    task automatic set_random();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = int'($urandom_range(0, 15));
                mb[i][j] = int'($urandom_range(0, 15));
            end
        end
        load();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
        steps = 0;
        #2;
        check_grid({tag, " rst"}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick(input string tag, input bit en);
        @(negedge clk);
        enable = en;
        @(posedge clk);
        #1;
        if (en && steps < 7) steps++;
        check_grid($sformatf("%s s%0d", tag, steps), steps);
    endtask

    task automatic run(input string tag, input int gap_at, input int gap_len);
        int gap = gap_len;
        do_reset(tag);
        while (steps < 7) begin
            if (steps == gap_at && gap > 0) begin
                tick(tag, 1'b0);
                gap--;
            end else begin
                tick(tag, 1'b1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            a_row[i] = '0;
            b_col[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_grid("por", 0);

        set_hex(12'h123, 12'h456, 12'h789, 12'h147, 12'h258, 12'h369);
        run("seq", -1, 0);
        check("seq c11 const", int'(c_out[0][0]), 30);
        check("seq c33 const", int'(c_out[2][2]), 150);

        set_hex(12'h722, 12'h409, 12'h789, 12'hA47, 12'h258, 12'h4B2);
        run("mix", -1, 0);
        check("mix c11 const", int'(c_out[0][0]), 92);
        check("mix c33 const", int'(c_out[2][2]), 134);

        set_hex(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        run("max", -1, 0);
        check("max c22 wrap", int'(c_out[1][1]), 163);

        set_hex(12'h123, 12'h456, 12'h789, 12'h147, 12'h258, 12'h369);
        run("gap", 3, 3);

        // Completed run must ignore enable and input changes.
        for (int t = 0; t < 10; t++) begin
            a_row[t % 3] = 12'($urandom);
            b_col[t % 3] = 12'($urandom);
            tick("hold", 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #3;
        rst = 1'b1;
        steps = 0;
        #1;
        check_grid("async", 0);
        @(negedge clk);
        rst = 1'b0;

        set_random();
        do_reset("abort");
        repeat (4) tick("abort", 1'b1);
        set_random();
        run("rerun", -1, 0);

        for (int r = 0; r < 6; r++) begin
            set_random();
            run($sformatf("rnd%0d", r), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_array_3x3.md
Name: systolic_array_3x3

Overview:
- Computes C = A x B for two 3x3 matrices of unsigned 4-bit elements.
- Uses a 3x3 grid of multiply-accumulate processing elements (PEs).
- A is presented as three packed rows and B as three packed columns. The block injects them internally with a diagonal skew.
- Nine 8-bit results are produced, plus a done flag (MULTI_OVER). One multiplication runs per reset; reset starts the next one.

Parameters:
- WIDTH, 12: packed row/column width (3 elements x 4 bits).
- WIDTH_SUM, 8: width of each result element and PE accumulator.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- ENABLE  in  1  high = advance one step per clock; low = freeze all state
- A_ROW1, A_ROW2, A_ROW3  in  WIDTH each  rows 1-3 of A, packed {a_r1, a_r2, a_r3}, element 1 in bits [11:8]
- B_COLOUM1, B_COLOUM2, B_COLOUM3  in  WIDTH each  columns 1-3 of B, packed {b_1c, b_2c, b_3c}, element 1 in bits [11:8]
- C_OUT_1x1 … C_OUT_3x3  out  WIDTH_SUM each  result C[r][c] for r, c in 1..3 (nine ports, row-major names)
- MULTI_OVER  out  1  high once all nine results are final

Behaviour:
- Reset (RST=1, asynchronous): step counter = 0, all PE accumulators and a/b pipeline registers = 0, all C_OUT = 0, MULTI_OVER = 0. Reset asserted mid-operation aborts the computation immediately.
- Inputs A_ROW*/B_COLOUM* must stay stable from reset release until MULTI_OVER = 1. Changing them mid-run gives undefined results.
- Step counter cnt (3 bits): increments on each rising edge with ENABLE=1 and RST=0. It saturates at 7.
- Feeders (0-based indices), combinational from cnt:
  - left input of row i = A[i][cnt-i] when 0 <= cnt-i <= 2, else 0;
  - top input of column j = B[cnt-j][j] when 0 <= cnt-j <= 2, else 0.
- PE(i,j) on each enabled edge while cnt < 7:
  - acc <= acc + a_in*b_in;
  - a_out <= a_in, passed to PE(i,j+1);
  - b_out <= b_in, passed to PE(i+1,j).
- PE(i,j) therefore consumes A[i][k]*B[k][j] on the edge where cnt = k+i+j. The last product lands in PE(3,3) at cnt = 6.
- MULTI_OVER: registered. It goes high on the 7th enabled edge after reset (cnt becomes 7) and stays high until reset.
- Once cnt = 7 the accumulators hold and ignore ENABLE and the inputs.
- ENABLE=0: counter, PE registers and MULTI_OVER all hold.
- C_OUT_rxc = acc of PE(r,c), driven continuously. Intermediate partial sums are visible while the run is in progress.
- Arithmetic:
  - 4x4 unsigned products are 8 bits; accumulation is modulo 2^WIDTH_SUM (wrap, no saturation).
  - The maximum true sum is 675, so overflow is possible. No overflow flag is provided.
- Latency: 7 enabled clocks from reset release to MULTI_OVER = 1 with final results.

Decomposition:
- Shared package systolic_pkg holds:
  - constants ELEM_W = 4, N = 3, WIDTH = 12, WIDTH_SUM = 8, LAST_STEP = 7;
  - a typedef for a 4-bit element and one for an 8-bit accumulator.
- Sub-module systolic_pe: registered a/b pass-through plus MAC accumulator, with CLK, RST, enable and hold inputs. It is instantiated 9 times in a generate loop.
- The top level contains the step counter, skew feeders, done flag and output mapping.

Test Plan:
- A = B = [[1,2,3],[4,5,6],[7,8,9]] (rows 0x123/0x456/0x789, cols 0x147/0x258/0x369), reset then ENABLE=1 for 7 clocks -> C = 30, 36, 42 / 66, 81, 96 / 102, 126, 150; MULTI_OVER rises on the 7th edge, not before.
- Reset, then rows 0x722/0x409/0x789 and cols 0xA47/0x258/0x4B2, run -> C = 92, 40, 54 / 103, 80, 34 / 165, 126, 134.
- All elements 0xF, run -> every C = 675 mod 256 = 163.
- First case with ENABLE dropped low for 3 cycles at cnt = 3 -> outputs freeze during the gap; final results are unchanged and MULTI_OVER arrives 3 clocks later.
- Run to completion, then clock 10 more cycles and change the inputs -> outputs and MULTI_OVER hold. Assert RST asynchronously between clock edges -> all outputs are 0 immediately.
- Assert RST at cnt = 4 during a run, release, then run again -> results are correct for the current inputs with no residue from the aborted run.
